// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  function automatic int cnt_width(input int in_w);
    if (in_w > 1) begin
      return $clog2(in_w);
    end else begin
      return 1;
    end
  endfunction

  // True when DIGITS decimal digits can hold every IN_W-bit unsigned value.
  function automatic bit digits_fit(input int in_w, input int digits);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p > ((64'd1 << in_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// One double-dabble digit correction: nibbles of 5 or more get +3 before the shift.
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // digit adjust, wraps within 4 bits by construction (max 9+3=12)
  always_comb begin
    if (din >= ADD3_THRESH) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the HEX digit decoders.
// Optional feature macro: LEADING_ZERO_BLANK_EN (drives the leading-zero blank mask).
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IN_W-1:0]               bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]             blank
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = cnt_width(IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  if (!digits_fit(IN_W, DIGITS)) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small to represent 2^IN_W-1");
  end

  logic [1:0]       state_r, state_nxt_s;
  logic [SR_W-1:0]  sr_r, sr_nxt_s, sr_adj_s, sr_shift_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [BCD_W-1:0] final_bcd_s;
  logic [DIGITS-1:0] blank_nxt_s;
  logic             load_s;
  logic             unused_msb_s;

  assign sr_adj_s[IN_W-1:0] = sr_r[IN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (sr_r[IN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .dout (sr_adj_s[IN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // The top bit falls off on every shift; digit fit guarantees it is zero.
  assign unused_msb_s = sr_adj_s[SR_W-1];
  assign sr_shift_s   = {sr_adj_s[SR_W-2:0], 1'b0};
  assign final_bcd_s  = sr_shift_s[SR_W-1:IN_W];

`ifdef LEADING_ZERO_BLANK_EN
  // blank digit i (i>=1) when it and every more significant digit are zero
  always_comb begin
    logic zero_above;
    blank_nxt_s = {DIGITS{1'b0}};
    zero_above  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above     = zero_above & (final_bcd_s[BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0);
      blank_nxt_s[i] = zero_above;
    end
  end
`else
  assign blank_nxt_s = {DIGITS{1'b0}};
`endif

  // next-state, shift register and counter update
  always_comb begin
    state_nxt_s = state_r;
    sr_nxt_s    = sr_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
          sr_nxt_s    = {{BCD_W{1'b0}}, bin_in};
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        sr_nxt_s  = sr_shift_s;
        cnt_nxt_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = DONE;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sr_r    <= {SR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= {BCD_W{1'b0}};
      blank   <= {DIGITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      sr_r    <= sr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy    <= (state_nxt_s == SHIFT);
      done    <= (state_nxt_s == DONE);
      if (load_s) begin
        bcd_out <= final_bcd_s;
        blank   <= blank_nxt_s;
      end else begin
        bcd_out <= bcd_out;
        blank   <= blank;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed + randomized bench for bin_to_bcd_seq against a decimal arithmetic model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  int checks   = 0;
  int failures = 0;
  logic [19:0] prev_bcd = 20'd0;
  logic [4:0]  prev_blank = 5'd0;

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] b;
    int p;
    b = 5'd0;
    p = 1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 5; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One conversion; poke=1 fires an ignored start with bin_in=999 mid-SHIFT.
  task automatic conv(input int v, input bit poke);
    bin_in = 16'(v);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("busy_shift", 32'(busy), 32'd1);
      chk("done_low_shift", 32'(done), 32'd0);
      chk("bcd_hold_shift", 32'(bcd_out), 32'(prev_bcd));
      if (poke && c == 5) begin
        bin_in = 16'd999;
        start  = 1'b1;
      end else if (poke && c == 6) begin
        start = 1'b0;
      end
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("bcd_value", 32'(bcd_out), 32'(ref_bcd(v)));
    chk("blank_value", 32'(blank), 32'(ref_blank(v)));
    prev_bcd   = ref_bcd(v);
    prev_blank = ref_blank(v);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("bcd_hold_after", 32'(bcd_out), 32'(prev_bcd));
    if (poke) begin
      for (int c = 0; c < 20; c++) begin
        chk("no_extra_done", 32'(done), 32'd0);
        tick();
      end
    end
  endtask

  initial begin
    int pulses;
    int first_c;
    int second_c;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 16'd0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    reset = 1'b0;
    tick();

    conv(0, 1'b0);
    conv(1234, 1'b0);
    conv(65535, 1'b0);
    conv(10, 1'b0);
    for (int n = 0; n < 8; n++) begin
      conv(int'($urandom_range(0, 65535)), 1'b0);
    end

    // start/bin_in changes during SHIFT must not affect the running conversion
    conv(42, 1'b1);
    conv(999, 1'b0);

    // reset mid-conversion discards the in-flight result
    bin_in = 16'd4321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_blank", 32'(blank), 32'd0);
    reset = 1'b0;
    prev_bcd   = 20'd0;
    prev_blank = 5'd0;
    for (int c = 0; c < 20; c++) begin
      chk("midrst_no_done", 32'(done), 32'd0);
      tick();
    end

    // start held high: one conversion per 18 cycles
    bin_in   = 16'd7;
    start    = 1'b1;
    pulses   = 0;
    first_c  = 0;
    second_c = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        pulses++;
        if (pulses == 1) first_c = c;
        else if (pulses == 2) second_c = c;
        chk("held_bcd", 32'(bcd_out), 32'(ref_bcd(7)));
        chk("held_blank", 32'(blank), 32'(ref_blank(7)));
      end else begin
        chk("held_hold", 32'(bcd_out), (pulses == 0) ? 32'(prev_bcd) : 32'(ref_bcd(7)));
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_first", 32'(first_c), 32'd17);
    chk("held_second", 32'(second_c), 32'd35);
    for (int c = 0; c < 20; c++) tick();
    chk("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
